// File: rtl/seven_segment_capture.sv
// ============================================================================
// Module      : seven_segment_capture
// Description : Recovers hex digits from a multiplexed seven-segment drive,
//               assembling one frame per full digit scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [7:0]                segmentEnableN,
  input  logic [NUM_DIGITS-1:0]     digitEnableN,
  input  logic                      clearErrors,
  output logic [4*NUM_DIGITS-1:0]   data,
  output logic [NUM_DIGITS-1:0]     pointEnable,
  output logic                      frameValid,
  output logic [NUM_DIGITS-1:0]     decodeError,
  output logic                      multiError,
  output logic                      stale
);

  localparam int                    c_tw          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]            c_settle_max  = 8'(SETTLE_CYCLES);
  localparam logic [7:0]            c_settle_last = 8'(SETTLE_CYCLES - 1);
  localparam logic [c_tw-1:0]       c_timeout     = c_tw'(TIMEOUT_CYCLES);
  localparam logic [c_tw-1:0]       c_tout_one    = c_tw'(1);
  localparam logic [NUM_DIGITS-1:0] c_dig_one     = NUM_DIGITS'(1);

  // Returns {valid, nibble}; unknown patterns map to nibble 0, valid 0.
  function automatic logic [4:0] decode_segments(input logic [6:0] pattern);
    logic [4:0] result;
    case (pattern)
      7'h3F:   result = 5'h10;
      7'h06:   result = 5'h11;
      7'h5B:   result = 5'h12;
      7'h4F:   result = 5'h13;
      7'h66:   result = 5'h14;
      7'h6D:   result = 5'h15;
      7'h7D:   result = 5'h16;
      7'h07:   result = 5'h17;
      7'h7F:   result = 5'h18;
      7'h6F:   result = 5'h19;
      7'h77:   result = 5'h1A;
      7'h7C:   result = 5'h1B;
      7'h39:   result = 5'h1C;
      7'h5E:   result = 5'h1D;
      7'h79:   result = 5'h1E;
      7'h71:   result = 5'h1F;
      default: result = 5'h00;
    endcase
    return result;
  endfunction

  logic [7:0]              r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_dig_s1, r_dig_s2, r_dig_prev;
  logic [7:0]              r_settle;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_pt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [c_tw-1:0]         r_timeout;

  logic                    w_stable;
  logic                    w_sample;
  logic [NUM_DIGITS-1:0]   w_low;
  logic                    w_multi_low;
  logic                    w_accept;
  logic                    w_multi_hit;
  logic [4:0]              w_decoded;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_de_set;
  logic [c_tw-1:0]         w_timeout_next;

  assign w_stable    = (r_seg_s2 == r_seg_prev) && (r_dig_s2 == r_dig_prev);
  assign w_sample    = w_stable && (r_settle == c_settle_last);
  assign w_low       = ~r_dig_s2;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi_low = (w_low & (w_low - c_dig_one)) != '0;
  assign w_accept    = w_sample && (|w_low) && !w_multi_low;
  assign w_multi_hit = w_sample && w_multi_low;
  assign w_decoded   = decode_segments(~r_seg_s2[6:0]);
  assign w_commit    = &r_seen;
  assign w_de_set    = (w_accept && !w_decoded[4]) ? w_low : '0;

  always_comb begin
    w_timeout_next = r_timeout;
    if (w_accept) begin
      w_timeout_next = '0;
    end else if (r_timeout != c_timeout) begin
      w_timeout_next = r_timeout + c_tout_one;
    end
  end

  // Synchronizers idle at all-ones so reset looks like a blanked display.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_dig_s1   <= '1;
      r_dig_s2   <= '1;
      r_dig_prev <= '1;
      r_settle   <= '0;
    end else begin
      r_seg_s1   <= segmentEnableN;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_dig_s1   <= digitEnableN;
      r_dig_s2   <= r_dig_s1;
      r_dig_prev <= r_dig_s2;
      if (!w_stable) begin
        r_settle <= '0;
      end else if (r_settle != c_settle_max) begin
        r_settle <= r_settle + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_shadow    <= '0;
      r_shadow_pt <= '0;
      r_seen      <= '0;
      data        <= '0;
      pointEnable <= '0;
      frameValid  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_accept && w_low[i]) begin
          r_shadow[4*i +: 4] <= w_decoded[3:0];
          r_shadow_pt[i]     <= ~r_seg_s2[7];
        end
      end
      // A sample landing in the commit cycle starts the next frame.
      r_seen     <= (w_commit ? '0 : r_seen) | (w_accept ? w_low : '0);
      frameValid <= w_commit;
      if (w_commit) begin
        data        <= r_shadow;
        pointEnable <= r_shadow_pt;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      decodeError <= '0;
      multiError  <= 1'b0;
      r_timeout   <= '0;
      stale       <= 1'b0;
    end else begin
      decodeError <= (clearErrors ? '0 : decodeError) | w_de_set;
      multiError  <= (multiError && !clearErrors) || w_multi_hit;
      r_timeout   <= w_timeout_next;
      if (w_commit) begin
        stale <= 1'b0;
      end else if (w_timeout_next == c_timeout) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
